// File: rtl/axil_pkg.sv
// AXI4-Lite response/protection constants and the command master FSM encoding.
package axil_pkg;

  localparam logic [1:0] AXIL_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_EXOKAY = 2'b01;
  localparam logic [1:0] AXIL_SLVERR = 2'b10;
  localparam logic [1:0] AXIL_DECERR = 2'b11;

  localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4,
    ST_RESP         = 3'd5
  } state_t;

  // EXOKAY counts as an error: this master never issues exclusive accesses.
  function automatic logic is_error(input logic [1:0] resp);
    logic err;
    case (resp)
      AXIL_OKAY:   err = 1'b0;
      AXIL_EXOKAY: err = 1'b1;
      AXIL_SLVERR: err = 1'b1;
      AXIL_DECERR: err = 1'b1;
      default:     err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/axil_cmd_master.sv
// Turns a command valid/ready stream into single AXI4-Lite reads/writes, one outstanding,
// and returns each result (data + resp) on a response valid/ready stream.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 10,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                      axi_clock,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_we,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_we,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      busy,
  output logic [ERR_CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH+1:0]     m_axil_awaddr,
  output logic [2:0]                m_axil_awprot,
  output logic                      m_axil_awvalid,
  input  logic                      m_axil_awready,
  output logic [DATA_WIDTH-1:0]     m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axil_wstrb,
  output logic                      m_axil_wvalid,
  input  logic                      m_axil_wready,
  input  logic [1:0]                m_axil_bresp,
  input  logic                      m_axil_bvalid,
  output logic                      m_axil_bready,
  output logic [ADDR_WIDTH+1:0]     m_axil_araddr,
  output logic [2:0]                m_axil_arprot,
  output logic                      m_axil_arvalid,
  input  logic                      m_axil_arready,
  input  logic [DATA_WIDTH-1:0]     m_axil_rdata,
  input  logic [1:0]                m_axil_rresp,
  input  logic                      m_axil_rvalid,
  output logic                      m_axil_rready
);

  state_t                    state_reg, state_next;
  logic                      aw_done_reg, aw_done_next;
  logic                      w_done_reg, w_done_next;
  logic [ADDR_WIDTH-1:0]     addr_reg;
  logic [DATA_WIDTH-1:0]     wdata_reg;
  logic [DATA_WIDTH/8-1:0]   wstrb_reg;
  logic                      rsp_we_reg;
  logic [DATA_WIDTH-1:0]     rsp_rdata_reg;
  logic [1:0]                rsp_resp_reg;
  logic [ERR_CNT_WIDTH-1:0]  err_count_reg;

  logic cmd_hs, aw_hs, w_hs, b_hs, r_hs, resp_err;

  assign cmd_ready      = (state_reg == ST_IDLE) && !rst;
  assign busy           = (state_reg != ST_IDLE);
  assign m_axil_awvalid = (state_reg == ST_WR_ADDR_DATA) && !aw_done_reg;
  assign m_axil_wvalid  = (state_reg == ST_WR_ADDR_DATA) && !w_done_reg;
  assign m_axil_bready  = (state_reg == ST_WR_RESP);
  assign m_axil_arvalid = (state_reg == ST_RD_ADDR);
  assign m_axil_rready  = (state_reg == ST_RD_DATA);
  assign rsp_valid      = (state_reg == ST_RESP);

  assign m_axil_awaddr  = {addr_reg, 2'b00};
  assign m_axil_araddr  = {addr_reg, 2'b00};
  assign m_axil_awprot  = AXIL_PROT_DEFAULT;
  assign m_axil_arprot  = AXIL_PROT_DEFAULT;
  assign m_axil_wdata   = wdata_reg;
  assign m_axil_wstrb   = wstrb_reg;

  assign rsp_we    = rsp_we_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_resp  = rsp_resp_reg;
  assign err_count = err_count_reg;

  assign cmd_hs   = cmd_valid && cmd_ready;
  assign aw_hs    = m_axil_awvalid && m_axil_awready;
  assign w_hs     = m_axil_wvalid && m_axil_wready;
  assign b_hs     = m_axil_bvalid && m_axil_bready;
  assign r_hs     = m_axil_rvalid && m_axil_rready;
  assign resp_err = (b_hs && is_error(m_axil_bresp)) || (r_hs && is_error(m_axil_rresp));

  always_comb begin
    state_next   = state_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    case (state_reg)
      ST_IDLE: begin
        aw_done_next = 1'b0;
        w_done_next  = 1'b0;
        if (cmd_valid) state_next = cmd_we ? ST_WR_ADDR_DATA : ST_RD_ADDR;
      end
      ST_WR_ADDR_DATA: begin
        // A handshake in this cycle already counts as done.
        aw_done_next = aw_done_reg || aw_hs;
        w_done_next  = w_done_reg || w_hs;
        if (aw_done_next && w_done_next) state_next = ST_WR_RESP;
      end
      ST_WR_RESP: if (m_axil_bvalid) state_next = ST_RESP;
      ST_RD_ADDR: if (m_axil_arready) state_next = ST_RD_DATA;
      ST_RD_DATA: if (m_axil_rvalid) state_next = ST_RESP;
      ST_RESP:    if (rsp_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_clock) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      rsp_we_reg    <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= AXIL_OKAY;
      err_count_reg <= '0;
    end else begin
      state_reg   <= state_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      if (cmd_hs) begin
        addr_reg  <= cmd_addr;
        wdata_reg <= cmd_wdata;
        wstrb_reg <= cmd_wstrb;
      end
      if (b_hs) begin
        rsp_we_reg    <= 1'b1;
        rsp_rdata_reg <= '0;
        rsp_resp_reg  <= m_axil_bresp;
      end
      if (r_hs) begin
        rsp_we_reg    <= 1'b0;
        rsp_rdata_reg <= m_axil_rdata;
        rsp_resp_reg  <= m_axil_rresp;
      end
      if (resp_err && (err_count_reg != {ERR_CNT_WIDTH{1'b1}}))
        err_count_reg <= err_count_reg + 1'b1;
    end
  end

endmodule
